// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key codes,
// the row/column code table and small decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam logic [4:0] KEY_NONE = 5'd31;

  // Row-major table, entry index {row, col}; element 0 is r0c0
  localparam logic [15:0][4:0] KEY_TABLE = {
    5'd13, 5'd15, 5'd0,  5'd14,   // r3: *, 0, #, D
    5'd12, 5'd9,  5'd8,  5'd7,    // r2: 7, 8, 9, C
    5'd11, 5'd6,  5'd5,  5'd4,    // r1: 4, 5, 6, B
    5'd10, 5'd3,  5'd2,  5'd1     // r0: 1, 2, 3, A
  };

  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[{r, c}];
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Lowest-index row pulled low; only meaningful when some bit is low
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0]) return 2'd0;
    if (!r[1]) return 2'd1;
    if (!r[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle: row sense in, column drive and decoded key outputs.
// master is the scanner, slave is the keypad / observer.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] key;
  logic       keypad_pressed;
  logic       key_strobe;

  modport master (
    input  row,
    output col, key, keypad_pressed, key_strobe
  );

  modport slave (
    output row,
    input  col, key, keypad_pressed, key_strobe
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; two cycles of latency,
// resets to all-ones so idle pulled-up lines read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce; no backpressure.
// Key outputs register one cycle after DEBOUNCE_CYC stable low samples of the held row.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kp
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);

  logic [3:0]    srow;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    ci, ci_n;
  logic [1:0]    ri, ri_n;
  logic [3:0]    col_q;
  logic [4:0]    key_q, key_n;
  logic          pressed_q, pressed_n;
  logic          strobe_q, strobe_n;
  logic          row_hi;

  sync_2ff #(.W(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (kp.row),
    .q     (srow)
  );

  assign row_hi = srow[ri];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      cnt       <= '0;
      ci        <= 2'd0;
      ri        <= 2'd0;
      col_q     <= 4'b1110;
      key_q     <= KEY_NONE;
      pressed_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ci        <= ci_n;
      ri        <= ri_n;
      col_q     <= col_drive(ci_n);
      key_q     <= key_n;
      pressed_q <= pressed_n;
      strobe_q  <= strobe_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ci_n      = ci;
    ri_n      = ri;
    key_n     = key_q;
    pressed_n = pressed_q;
    strobe_n  = 1'b0;

    unique case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          if (srow != 4'hF) begin
            ri_n    = lowest_low(srow);
            state_n = DEB_PRESS;
          end else begin
            ci_n = ci + 2'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DEB_PRESS: begin
        if (row_hi) begin
          state_n = SCAN;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n   = PRESSED;
          cnt_n     = '0;
          key_n     = key_code(ri, ci);
          pressed_n = 1'b1;
          strobe_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // Column stays parked on ci, so other keys cannot disturb the held one
      PRESSED: begin
        if (row_hi) begin
          state_n = DEB_REL;
          cnt_n   = '0;
        end
      end

      DEB_REL: begin
        if (!row_hi) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n   = SCAN;
          cnt_n     = '0;
          ci_n      = 2'd0;
          key_n     = KEY_NONE;
          pressed_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = SCAN;
        cnt_n   = '0;
        ci_n    = 2'd0;
      end
    endcase
  end

  assign kp.col            = col_q;
  assign kp.key            = key_q;
  assign kp.keypad_pressed = pressed_q;
  assign kp.key_strobe     = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYC=16; a
// switch-matrix model turns held keys and the driven column into row levels.
module tb_keypad_scanner;

  localparam int SDIV = 4;
  localparam int DEB  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0][3:0] keys = '0;   // keys[row][col], 1 = held

  int checks = 0;
  int errors = 0;

  int strobe_cyc = 0;
  int strobe_rise = 0;
  int strobe_bad = 0;
  logic prev_strobe = 1'b0;
  logic prev_pressed = 1'b0;

  keypad_scanner_if kpif();

  keypad_scanner #(.SCAN_DIV(SDIV), .DEBOUNCE_CYC(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kpif)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] row_of(input logic [3:0][3:0] k, input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~|(k[i] & ~c);
    return r;
  endfunction

  assign kpif.row = row_of(keys, kpif.col);

  // Printed legend of a 4x4 phone-style keypad, as plain arithmetic
  function automatic int model_code(input int r, input int c);
    if (c == 3) return 10 + r;
    if (r < 3) return r * 3 + c + 1;
    if (c == 0) return 14;
    if (c == 1) return 0;
    return 15;
  endfunction

  function automatic int model_first(input logic [3:0][3:0] k, input int start);
    for (int n = 0; n < 4; n++) begin
      int c;
      c = (start + n) % 4;
      for (int r = 0; r < 4; r++)
        if (k[r][c]) return model_code(r, c);
    end
    return 31;
  endfunction

  always @(negedge clk) begin
    if (kpif.key_strobe === 1'b1) begin
      strobe_cyc++;
      if (!prev_strobe) strobe_rise++;
      if (kpif.keypad_pressed !== 1'b1 || prev_pressed) strobe_bad++;
    end
    prev_strobe  = kpif.key_strobe;
    prev_pressed = kpif.keypad_pressed;
  end

  task automatic wait_pressed(input logic lvl, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit && cycles < 0; i++) begin
      @(negedge clk);
      if (kpif.keypad_pressed === lvl) cycles = i;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (kpif.col !== 4'b1110 || kpif.key !== 5'd31 || kpif.keypad_pressed !== 1'b0 || kpif.key_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: col=%b key=%0d pressed=%b strobe=%b required col=1110 key=31 pressed=0 strobe=0",
               kpif.col, kpif.key, kpif.keypad_pressed, kpif.key_strobe);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (kpif.col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b required 1110", kpif.col); end
    checks++;
    if (kpif.key !== 5'd31) begin errors++; $display("FAIL reset_key: got %0d required 31", kpif.key); end
    checks++;
    if (kpif.keypad_pressed !== 1'b0 || kpif.key_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: pressed=%b strobe=%b required 0 0", kpif.keypad_pressed, kpif.key_strobe);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    keys = '0;
    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      exp_col = ~(4'b0001 << ((i / SDIV) % 4));
      checks++;
      if (kpif.col !== exp_col || kpif.keypad_pressed !== 1'b0 || kpif.key_strobe !== 1'b0 || kpif.key !== 5'd31) begin
        errors++;
        $display("FAIL idle_scan cycle %0d: col=%b pressed=%b strobe=%b key=%0d required col=%b idle outputs",
                 i, kpif.col, kpif.keypad_pressed, kpif.key_strobe, kpif.key, exp_col);
      end
    end
  endtask

  task automatic test_clean_press();
    int r, c, cyc, b_rise, b_cyc, b_bad, exp;
    for (int n = 0; n < 7; n++) begin
      if (n == 0) begin r = 1; c = 0; end
      else begin r = $urandom_range(0, 3); c = $urandom_range(0, 3); end
      exp = model_code(r, c);
      b_rise = strobe_rise; b_cyc = strobe_cyc; b_bad = strobe_bad;
      @(negedge clk);
      keys = '0;
      keys[r][c] = 1'b1;
      wait_pressed(1'b1, 200, cyc);
      checks++;
      if (cyc < 0) begin errors++; $display("FAIL press_timeout r%0dc%0d: no keypad_pressed within 200 cycles", r, c); end
      repeat ($urandom_range(4, 20)) @(negedge clk);
      checks++;
      if (kpif.key !== exp[4:0] || kpif.keypad_pressed !== 1'b1) begin
        errors++;
        $display("FAIL press_key r%0dc%0d: key=%0d pressed=%b required key=%0d pressed=1", r, c, kpif.key, kpif.keypad_pressed, exp);
      end
      checks++;
      if (strobe_rise - b_rise != 1 || strobe_cyc - b_cyc != 1 || strobe_bad != b_bad) begin
        errors++;
        $display("FAIL press_strobe r%0dc%0d: pulses=%0d high_cycles=%0d misaligned=%0d required 1 1 0",
                 r, c, strobe_rise - b_rise, strobe_cyc - b_cyc, strobe_bad - b_bad);
      end
      keys = '0;
      wait_pressed(1'b0, 60, cyc);
      checks++;
      if (cyc < DEB || cyc > DEB + 6) begin
        errors++;
        $display("FAIL release_time r%0dc%0d: pressed fell after %0d cycles required %0d..%0d", r, c, cyc, DEB, DEB + 6);
      end
      checks++;
      if (kpif.key !== 5'd31) begin errors++; $display("FAIL release_key r%0dc%0d: got %0d required 31", r, c, kpif.key); end
    end
  endtask

  task automatic test_bounce();
    int cyc, b_rise;
    b_rise = strobe_rise;
    keys = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      keys[3][1] = ~keys[3][1];
    end
    @(negedge clk);
    keys[3][1] = 1'b1;
    wait_pressed(1'b1, 200, cyc);
    repeat (5) @(negedge clk);
    checks++;
    if (cyc < 0 || kpif.key !== 5'd0) begin
      errors++;
      $display("FAIL bounce_key: wait=%0d key=%0d required accepted key 0", cyc, kpif.key);
    end
    checks++;
    if (strobe_rise - b_rise != 1) begin errors++; $display("FAIL bounce_strobes: got %0d required 1", strobe_rise - b_rise); end
    keys = '0;
    wait_pressed(1'b0, 60, cyc);

    // Chatter whose low runs never reach the debounce length
    b_rise = strobe_rise;
    for (int i = 0; i < 8; i++) begin
      keys[3][1] = 1'b1;
      repeat ($urandom_range(1, 10)) @(negedge clk);
      keys[3][1] = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (strobe_rise != b_rise || kpif.keypad_pressed !== 1'b0 || kpif.key !== 5'd31) begin
      errors++;
      $display("FAIL short_bounce: strobes=%0d pressed=%b key=%0d required 0 0 31",
               strobe_rise - b_rise, kpif.keypad_pressed, kpif.key);
    end
  endtask

  task automatic test_release_glitch();
    int cyc, b_rise;
    bit dropped;
    b_rise = strobe_rise;
    dropped = 0;
    @(negedge clk);
    keys = '0;
    keys[2][2] = 1'b1;
    wait_pressed(1'b1, 200, cyc);
    repeat (5) @(negedge clk);
    keys[2][2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (kpif.keypad_pressed !== 1'b1) dropped = 1;
    end
    keys[2][2] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (kpif.keypad_pressed !== 1'b1) dropped = 1;
    end
    checks++;
    if (cyc < 0 || dropped || kpif.key !== 5'd9) begin
      errors++;
      $display("FAIL glitch_hold: wait=%0d dropped=%0d key=%0d required held key 9", cyc, dropped, kpif.key);
    end
    checks++;
    if (strobe_rise - b_rise != 1) begin errors++; $display("FAIL glitch_strobes: got %0d required 1", strobe_rise - b_rise); end
    keys = '0;
    wait_pressed(1'b0, 60, cyc);
  endtask

  task automatic test_multi_key();
    int cyc, b_rise, exp;
    @(negedge clk);
    keys = '0;
    keys[0][3] = 1'b1;
    keys[2][3] = 1'b1;
    exp = model_first(keys, 0);
    wait_pressed(1'b1, 200, cyc);
    repeat (3) @(negedge clk);
    checks++;
    if (cyc < 0 || kpif.key !== exp[4:0]) begin
      errors++;
      $display("FAIL same_col: wait=%0d key=%0d required %0d", cyc, kpif.key, exp);
    end
    keys = '0;
    wait_pressed(1'b0, 60, cyc);

    // Scan restarts at column 0 after reset, so column 0 must win
    keys[1][0] = 1'b1;
    keys[1][2] = 1'b1;
    exp = model_first(keys, 0);
    pulse_reset();
    b_rise = strobe_rise;
    wait_pressed(1'b1, 200, cyc);
    repeat (3) @(negedge clk);
    checks++;
    if (cyc < 0 || kpif.key !== exp[4:0]) begin
      errors++;
      $display("FAIL scan_order: wait=%0d key=%0d required %0d", cyc, kpif.key, exp);
    end
    keys[0][0] = 1'b1;
    keys[3][3] = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (kpif.key !== exp[4:0] || kpif.keypad_pressed !== 1'b1 || strobe_rise - b_rise != 1) begin
      errors++;
      $display("FAIL second_key: key=%0d pressed=%b strobes=%0d required %0d 1 1",
               kpif.key, kpif.keypad_pressed, strobe_rise - b_rise, exp);
    end
    keys = '0;
    wait_pressed(1'b0, 60, cyc);
  endtask

  task automatic test_reset_mid_press();
    int cyc, b_rise;
    @(negedge clk);
    keys = '0;
    keys[1][2] = 1'b1;
    wait_pressed(1'b1, 200, cyc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cyc < 0 || kpif.keypad_pressed !== 1'b0 || kpif.key !== 5'd31 || kpif.key_strobe !== 1'b0 || kpif.col !== 4'b1110) begin
      errors++;
      $display("FAIL reset_mid_press: wait=%0d pressed=%b key=%0d strobe=%b col=%b required 0 31 0 1110",
               cyc, kpif.keypad_pressed, kpif.key, kpif.key_strobe, kpif.col);
    end
    b_rise = strobe_rise;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_pressed(1'b1, 200, cyc);
    repeat (3) @(negedge clk);
    checks++;
    if (cyc < 0 || kpif.key !== 5'd6 || strobe_rise - b_rise != 1) begin
      errors++;
      $display("FAIL redetect: wait=%0d key=%0d strobes=%0d required key 6 with 1 strobe", cyc, kpif.key, strobe_rise - b_rise);
    end
    keys = '0;
    wait_pressed(1'b0, 60, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_multi_key();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n; no other clock or reset.
REQ-002 Parameter SCAN_DIV, default 5000, clk cycles each column is driven before its rows are sampled (100 us at 50 MHz).
REQ-003 Parameter DEBOUNCE_CYC, default 1000000, consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz).
REQ-004 Port clk, input, 1, system clock; all logic rising-edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port row, input, 4, keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-007 Port col, output, 4, keypad column drive, active-low, one-hot-low while scanning or holding.
REQ-008 Port key, output, 5, code of the accepted key; valid while keypad_pressed is high.
REQ-009 Port keypad_pressed, output, 1, high while a debounced key is held.
REQ-010 Port key_strobe, output, 1, single-cycle pulse on the cycle keypad_pressed rises.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer; all decisions use only the synchronized value (srow).
REQ-012 Key map (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D; codes: digit = value, A=10, B=11, C=12, D=13, *=14, #=15; KEY_NONE=31.
REQ-013 FSM states: SCAN, DEB_PRESS, PRESSED, DEB_REL.
REQ-014 SCAN: drive col index ci low; a divider counts 0..SCAN_DIV-1; at terminal count, sample srow.
REQ-015 SCAN sample with any srow bit low: latch ci and the lowest-index low row (ri) -> DEB_PRESS, counter cleared; otherwise ci <= ci+1, wrapping 3->0.
REQ-016 DEB_PRESS: col held on ci; counter increments each cycle srow[ri] is low; srow[ri] high -> SCAN, same ci, counters cleared.
REQ-017 DEB_PRESS with counter reaching DEBOUNCE_CYC-1 while srow[ri] low: next cycle key <= map(ri,ci), keypad_pressed <= 1, key_strobe <= 1 for exactly one cycle -> PRESSED.
REQ-018 PRESSED: col held; other keys (any row/col) ignored; srow[ri] high -> DEB_REL, counter cleared.
REQ-019 DEB_REL: keypad_pressed stays 1; srow[ri] low again -> PRESSED, counter cleared, no new key_strobe.
REQ-020 DEB_REL with srow[ri] high for DEBOUNCE_CYC consecutive cycles: keypad_pressed <= 0, key <= KEY_NONE -> SCAN at ci = 0.
REQ-021 Multiple keys in the same column: lowest row index wins. Keys in different columns: the first column reached in scan order wins.
REQ-022 Counters SHALL be $clog2(max)+1 bits wide, saturate at no point, and clear on every state change.
REQ-023 key_strobe and keypad_pressed SHALL be registered outputs, glitch-free.

Reset
REQ-024 rst_n low SHALL asynchronously force: state SCAN, ci 0, col 4'b1110, key KEY_NONE, keypad_pressed 0, key_strobe 0, all counters and synchronizer flops cleared (synchronizer to 1).
REQ-025 Reset asserted mid-press SHALL drop keypad_pressed immediately; after release of rst_n the held key is re-detected and re-debounced as a new press.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum, KEY_NONE, and the 4x4 key-code table.
REQ-027 One sub-module, sync_2ff (4-bit, reset to all-ones), SHALL implement the row synchronizer; the rest is a single FSM module.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=16)
REQ-028 Press r1c0 clean -> key=4, keypad_pressed=1, key_strobe one-cycle pulse; release -> keypad_pressed=0 after 16 stable cycles, key=31.
REQ-029 Press r3c1 with 5-cycle bounce then stable -> exactly one key_strobe, key=0; bouncing for <16 cycles then release -> no strobe.
REQ-030 Hold r2c2 (key 9), release glitch of 8 cycles -> keypad_pressed stays 1, no second strobe.
REQ-031 r0c3 and r2c3 pressed together -> key=10; r1c0 and r1c2 together from ci=0 -> key=4; second key while PRESSED -> ignored.
REQ-032 rst_n low while key 6 held -> outputs reset asynchronously; after rst_n high -> key=6 re-accepted with a new strobe.
REQ-033 No key for 64 cycles -> col cycles 1110,1101,1011,0111,1110 with 4 cycles each, outputs idle.
